rom_arbiter: RTL and testbench

Shares the single 16K x 8 program ROM between two requesters: port A (6502 CPU fetch/read path, high priority) and port B (self-test checksum / debug readback, low priority). It sequences each access: it drives the ROM address and active-low enable, waits a configurable read latency, then captures the ROM data and returns it to the granted port. A bounded-starvation rule guarantees port B progress under continuous CPU traffic. Sits between the CPU/debug address decoders and the ROM.

---
 rtl/rom_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_rom_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one program ROM between two requesters. Port A (CPU fetch/read path)
// has priority. Port B (self-test checksum / debug readback) is guaranteed
// progress: after MAX_WAIT consecutive A grants while B is waiting, B wins the
// next decision.
//
// Each access: capture the winner's address onto rom_addr, hold rom_ena_l low
// for RD_LAT cycles, sample rom_data on the last of those cycles, return it to
// the owner with a one-cycle valid pulse. Only one access is outstanding at a
// time. Between accesses rom_ena_l returns high for at least one cycle so the
// tri-state ROM bus gets a turnaround cycle.
//
// Parameters
//   ADDR_W    ROM address width
//   DATA_W    ROM data width
//   RD_LAT    cycles rom_ena_l is held low before data is sampled (1..3)
//   MAX_WAIT  consecutive A grants tolerated while B waits (1..15)
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst_l      synchronous active-low reset
//   a_req      port A request, held with a_addr until a_ack
//   a_addr     port A address
//   a_ack      one-cycle pulse: A request accepted (first cycle of the read)
//   a_valid    one-cycle pulse: a_rdata holds new data
//   a_rdata    last data returned to A (held until the next a_valid)
//   b_*        same as A for port B
//   rom_addr   ROM address, holds its last value while idle
//   rom_ena_l  ROM output enable, active low
//   rom_data   ROM data, undriven while rom_ena_l is high
// -----------------------------------------------------------------------------
module rom_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_l,

  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ena_l,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Latency counter value on the edge where rom_data is captured.
  localparam logic [1:0] LAST_CNT   = 2'(RD_LAT - 1);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e              state_q,   state_d;
  logic                owner_q,   owner_d;     // 0: port A, 1: port B
  logic [1:0]          cnt_q,     cnt_d;
  logic [3:0]          wait_q,    wait_d;      // A grants while B waits
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic                a_ack_q,   a_ack_d;
  logic                b_ack_q,   b_ack_d;
  logic                a_valid_q, a_valid_d;
  logic                b_valid_q, b_valid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                grant_b;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_valid_d = 1'b0;
    b_valid_d = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    // B wins when it is the only requester, or when it has already watched
    // MAX_WAIT A grants go by.
    grant_b = b_req && (!a_req || (wait_q >= MAX_WAIT_C));

    case (state_q)
      ST_IDLE: begin
        // A B requester that lets go forfeits its accumulated wait.
        if (!b_req) begin
          wait_d = 4'd0;
        end

        if (a_req || b_req) begin
          state_d = ST_READ;
          owner_d = grant_b;
          cnt_d   = 2'd0;
          addr_d  = grant_b ? b_addr : a_addr;
          a_ack_d = !grant_b;
          b_ack_d = grant_b;

          if (grant_b) begin
            wait_d = 4'd0;
          end else if (b_req && (wait_q < MAX_WAIT_C)) begin
            wait_d = wait_q + 4'd1;
          end
        end
      end

      ST_READ: begin
        cnt_d = cnt_q + 2'd1;
        // rom_data is only looked at here, while rom_ena_l is low, so an
        // undriven bus during idle never reaches the rdata registers.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
          if (owner_q) begin
            b_rdata_d = rom_data;
            b_valid_d = 1'b1;
          end else begin
            a_rdata_d = rom_data;
            a_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      // Reset also aborts an access in flight: the pending valid is dropped.
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= 2'd0;
      wait_q    <= 4'd0;
      addr_q    <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Enable follows the state directly: low for exactly the RD_LAT READ cycles,
  // high in every IDLE cycle.
  assign rom_ena_l = (state_q != ST_READ);
  assign rom_addr  = addr_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
`timescale 1ns/1ps
// Bench for rom_arbiter: three instances (RD_LAT = 1, 2, 3; MAX_WAIT = 4)
// share one clock. A transaction-level model predicts, for each instance, the
// cycle of every ack/valid, the enable window, rom_addr and the rdata values;
// every output is compared every cycle. Directed phases reproduce the
// single-read, fairness, drop/re-request and reset-abort scenarios, then a
// randomized phase interleaves requests on all instances.
module tb_rom_arbiter;

  localparam int NI   = 3;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_l     [NI];
  logic          a_req     [NI];
  logic          b_req     [NI];
  logic [AW-1:0] a_addr    [NI];
  logic [AW-1:0] b_addr    [NI];
  logic          a_ack     [NI];
  logic          b_ack     [NI];
  logic          a_valid   [NI];
  logic          b_valid   [NI];
  logic [DW-1:0] a_rdata   [NI];
  logic [DW-1:0] b_rdata   [NI];
  logic [AW-1:0] rom_addr  [NI];
  logic          rom_ena_l [NI];
  logic [DW-1:0] rom_data  [NI];
  logic [DW-1:0] rom_mem   [1<<AW];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rom_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1), .MAX_WAIT(MAXW)
    ) u_dut (
      .clk(clk), .rst_l(rst_l[g]),
      .a_req(a_req[g]), .a_addr(a_addr[g]), .a_ack(a_ack[g]),
      .a_valid(a_valid[g]), .a_rdata(a_rdata[g]),
      .b_req(b_req[g]), .b_addr(b_addr[g]), .b_ack(b_ack[g]),
      .b_valid(b_valid[g]), .b_rdata(b_rdata[g]),
      .rom_addr(rom_addr[g]), .rom_ena_l(rom_ena_l[g]), .rom_data(rom_data[g])
    );
    // ROM drives the bus only while enabled; otherwise it floats.
    assign rom_data[g] = rom_ena_l[g] ? {DW{1'bx}} : rom_mem[rom_addr[g]];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int cur_g    = 0;

  // Reference model: one access at a time, described by event cycles.
  bit            mvalid    [NI];
  int            free_at   [NI];   // first cycle whose closing edge may grant
  int            ack_at    [NI];
  int            vld_at    [NI];
  bit            own_b     [NI];
  int            streak    [NI];   // A grants seen by a waiting B
  logic [AW-1:0] last_addr [NI];
  logic [DW-1:0] pend_data [NI];
  logic [DW-1:0] exp_rd    [NI][2];

  // Requesters.
  bit            pend  [NI][2];
  logic [AW-1:0] paddr [NI][2];
  int            prob  [NI][2];

  // Observations of the DUT.
  int  obs_ack [NI][2];
  int  obs_vld [NI][2];
  int  vld_cnt [NI][2];
  int  ena_low [NI];
  int  act     [NI][2];
  byte glog[$];
  int  gcyc[$];
  int  log_g = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s (dut%0d, cycle %0d): got %0h, expected %0h", tag, cur_g, cyc, got, exp);
    end
  endtask

  task automatic clear_obs(input int g);
    for (int p = 0; p < 2; p++) begin
      obs_ack[g][p] = -1;
      obs_vld[g][p] = -1;
      vld_cnt[g][p] = 0;
      act[g][p]     = 0;
    end
    ena_low[g] = 0;
  endtask

  // Middle of cycle cyc: compare outputs, record observations, advance requesters.
  task automatic sense();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      cur_g = g;
      if (mvalid[g]) begin
        if (vld_at[g] == cyc) exp_rd[g][own_b[g]] = pend_data[g];
        check("a_ack",     a_ack[g],     (ack_at[g] == cyc) && !own_b[g]);
        check("b_ack",     b_ack[g],     (ack_at[g] == cyc) &&  own_b[g]);
        check("a_valid",   a_valid[g],   (vld_at[g] == cyc) && !own_b[g]);
        check("b_valid",   b_valid[g],   (vld_at[g] == cyc) &&  own_b[g]);
        check("rom_ena_l", rom_ena_l[g], !((cyc >= ack_at[g]) && (cyc < vld_at[g])));
        check("rom_addr",  rom_addr[g],  last_addr[g]);
        check("a_rdata",   a_rdata[g],   exp_rd[g][0]);
        check("b_rdata",   b_rdata[g],   exp_rd[g][1]);

        if (a_ack[g]) begin
          obs_ack[g][0] = cyc;
          if (g == log_g) begin glog.push_back("A"); gcyc.push_back(cyc); end
        end
        if (b_ack[g]) begin
          obs_ack[g][1] = cyc;
          if (g == log_g) begin glog.push_back("B"); gcyc.push_back(cyc); end
        end
        if (a_valid[g]) begin obs_vld[g][0] = cyc; vld_cnt[g][0]++; end
        if (b_valid[g]) begin obs_vld[g][1] = cyc; vld_cnt[g][1]++; end
        if (a_ack[g] || a_valid[g]) act[g][0]++;
        if (b_ack[g] || b_valid[g]) act[g][1]++;
        if (!rom_ena_l[g]) ena_low[g]++;
      end
      for (int p = 0; p < 2; p++) begin
        if (mvalid[g] && ack_at[g] == cyc && int'(own_b[g]) == p) pend[g][p] = 1'b0;
        if (!pend[g][p] && ($urandom_range(99) < 32'(prob[g][p]))) begin
          pend[g][p]  = 1'b1;
          paddr[g][p] = AW'($urandom);
        end
      end
    end
  endtask

  // Effect of the edge closing cycle cyc on instance g.
  task automatic model_edge(input int g);
    bit ar, br, pb;
    if (!rst_l[g]) begin
      mvalid[g]    = 1'b1;
      free_at[g]   = cyc + 1;
      ack_at[g]    = -10;
      vld_at[g]    = -10;
      own_b[g]     = 1'b0;
      streak[g]    = 0;
      last_addr[g] = '0;
      exp_rd[g][0] = '0;
      exp_rd[g][1] = '0;
      return;
    end
    if (!mvalid[g] || cyc < free_at[g]) return;
    ar = pend[g][0];
    br = pend[g][1];
    pb = br && (!ar || streak[g] >= MAXW);
    if (ar || br) begin
      own_b[g]     = pb;
      last_addr[g] = paddr[g][pb];
      pend_data[g] = rom_mem[paddr[g][pb]];
      ack_at[g]    = cyc + 1;
      vld_at[g]    = cyc + (g + 1) + 1;
      free_at[g]   = vld_at[g];
    end
    if (!br || pb) streak[g] = 0;
    else if (streak[g] < MAXW) streak[g]++;
  endtask

  task automatic commit();
    for (int g = 0; g < NI; g++) begin
      a_req[g]  = pend[g][0];
      a_addr[g] = paddr[g][0];
      b_req[g]  = pend[g][1];
      b_addr[g] = paddr[g][1];
    end
    for (int g = 0; g < NI; g++) model_edge(g);
    @(posedge clk);
    cyc++;
  endtask

  task automatic tick();
    sense();
    commit();
  endtask

  task automatic drain();
    for (int g = 0; g < NI; g++) begin prob[g][0] = 0; prob[g][1] = 0; end
    repeat (12) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog (cycle %0d): got timeout, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int    t0;
    bit    dropped;
    bit    found;
    int    bpos;
    int    total;
    string seq;
    logic [AW-1:0] ad;

    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
    rom_mem[14'h1234] = 8'hA5;
    rom_mem[14'h3FFF] = 8'h5C;
    for (int g = 0; g < NI; g++) begin
      rst_l[g] = 1'b0;
      mvalid[g] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        pend[g][p] = 1'b0; paddr[g][p] = '0; prob[g][p] = 0;
      end
      a_req[g] = 1'b0; b_req[g] = 1'b0; a_addr[g] = '0; b_addr[g] = '0;
      clear_obs(g);
    end

    repeat (3) tick();
    for (int g = 0; g < NI; g++) rst_l[g] = 1'b1;
    repeat (3) tick();

    // Single A read, RD_LAT = 1.
    sense();
    clear_obs(0);
    pend[0][0] = 1'b1; paddr[0][0] = 14'h1234; t0 = cyc;
    commit();
    repeat (5) tick();
    sense();
    cur_g = 0;
    check("t1_ack_cycle", obs_ack[0][0] - t0, 1);
    check("t1_valid_cycle", obs_vld[0][0] - t0, 2);
    check("t1_rdata", a_rdata[0], 8'hA5);
    check("t1_ena_low_cycles", ena_low[0], 1);
    check("t1_b_silent", act[0][1], 0);
    commit();

    // Single B read, RD_LAT = 3.
    sense();
    clear_obs(2);
    pend[2][1] = 1'b1; paddr[2][1] = 14'h3FFF; t0 = cyc;
    commit();
    repeat (7) tick();
    sense();
    cur_g = 2;
    check("t2_ack_cycle", obs_ack[2][1] - t0, 1);
    check("t2_valid_cycle", obs_vld[2][1] - t0, 4);
    check("t2_rdata", b_rdata[2], 8'h5C);
    check("t2_ena_low_cycles", ena_low[2], 3);
    check("t2_a_silent", act[2][0], 0);
    commit();
    drain();

    // Both ports continuously requesting, RD_LAT = 1.
    log_g = 0; glog.delete(); gcyc.delete();
    prob[0][0] = 100; prob[0][1] = 100;
    for (int k = 0; k < 80 && glog.size() < 10; k++) tick();
    cur_g = 0;
    check("t3_grant_count", glog.size() >= 10, 1);
    seq = "AAAABAAAAB";
    if (glog.size() >= 10) begin
      for (int i = 0; i < 10; i++) check("t3_grant_order", glog[i], seq[i]);
      for (int i = 1; i < 10; i++) check("t3_grant_gap", gcyc[i] - gcyc[i-1], 2);
    end
    drain();

    // B drops after two A grants, re-requests later.
    glog.delete(); gcyc.delete(); dropped = 0;
    prob[0][0] = 100;
    sense(); pend[0][1] = 1'b1; paddr[0][1] = 14'h0100; commit();
    for (int k = 0; k < 40 && !dropped; k++) begin
      sense();
      if (glog.size() >= 2) begin pend[0][1] = 1'b0; dropped = 1; end
      commit();
    end
    cur_g = 0;
    check("t4_dropped", dropped, 1);
    if (glog.size() >= 2) begin
      check("t4_first_grant", glog[0], "A");
      check("t4_second_grant", glog[1], "A");
    end
    repeat (6) tick();
    sense(); glog.delete(); gcyc.delete();
    pend[0][1] = 1'b1; paddr[0][1] = 14'h0200;
    commit();
    found = 0; bpos = -1;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      for (int i = 0; i < glog.size(); i++)
        if (!found && glog[i] == "B") begin found = 1; bpos = i; end
    end
    cur_g = 0;
    check("t4_b_granted", found, 1);
    check("t4_a_grants_before_b", bpos, 4);
    log_g = -1;
    drain();

    // Reset in the first cycle of an A access, RD_LAT = 2.
    sense();
    pend[1][0] = 1'b1; paddr[1][0] = 14'h2222;
    commit();
    sense();
    cur_g = 1;
    check("t5_ack_before_reset", a_ack[1], 1);
    clear_obs(1);
    rst_l[1] = 1'b0;
    commit();
    sense();
    cur_g = 1;
    check("t5_ena_after_reset", rom_ena_l[1], 1);
    check("t5_addr_after_reset", rom_addr[1], 0);
    check("t5_rdata_after_reset", a_rdata[1], 0);
    rst_l[1] = 1'b1;
    commit();
    repeat (6) tick();
    sense();
    cur_g = 1;
    check("t5_no_valid_after_abort", vld_cnt[1][0], 0);
    pend[1][0] = 1'b1; paddr[1][0] = 14'h0ABC; ad = 14'h0ABC; t0 = cyc;
    commit();
    repeat (5) tick();
    sense();
    cur_g = 1;
    check("t5_fresh_valid_cycle", obs_vld[1][0] - t0, 3);
    check("t5_fresh_rdata", a_rdata[1], rom_mem[ad]);
    commit();
    drain();

    // Random interleaved traffic on all instances.
    for (int g = 0; g < NI; g++) begin
      clear_obs(g);
      prob[g][0] = 20 + int'($urandom_range(60));
      prob[g][1] = 20 + int'($urandom_range(60));
    end
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ((k % 250) == 249)
        for (int g = 0; g < NI; g++) begin
          prob[g][0] = int'($urandom_range(100));
          prob[g][1] = int'($urandom_range(100));
        end
    end
    drain();
    for (int g = 0; g < NI; g++) begin
      cur_g = g;
      total = vld_cnt[g][0] + vld_cnt[g][1];
      check("t6_enough_accesses", total >= 100, 1);
      check("t6_a_rdata_known", $isunknown(a_rdata[g]), 0);
      check("t6_b_rdata_known", $isunknown(b_rdata[g]), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
